// File: rtl/aig_response_inverter.sv
// Inverse lookup over a firmware-programmed truth table: given a response word, scan all
// entries in order and report the lowest matching input vector and how many entries match.
module aig_response_inverter #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tbl_we,
    input  logic [IN_W-1:0]  tbl_addr,
    input  logic [OUT_W-1:0] tbl_wdata,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [OUT_W-1:0] q_resp,
    output logic             r_valid,
    input  logic             r_ready,
    output logic             r_found,
    output logic [IN_W-1:0]  r_pattern,
    output logic [IN_W:0]    r_count,
    output logic             busy
);

    localparam int unsigned DEPTH = 2 ** IN_W;
    localparam logic [IN_W-1:0] LastIdx = IN_W'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e state_q, state_d;

    logic [OUT_W-1:0] data_q [DEPTH];
    logic [OUT_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;

    logic [OUT_W-1:0] qreg_q, qreg_d;
    logic [IN_W-1:0]  idx_q, idx_d;
    logic [IN_W:0]    cnt_q, cnt_d;
    logic             first_q, first_d;
    logic [IN_W-1:0]  pat_q, pat_d;

    logic             q_ready_q, q_ready_d;
    logic             r_valid_q, r_valid_d;
    logic             r_found_q, r_found_d;
    logic [IN_W-1:0]  r_pattern_q, r_pattern_d;
    logic [IN_W:0]    r_count_q, r_count_d;
    logic             busy_q, busy_d;

    logic             wr_en;
    logic             accept;
    logic             hit;

    // Writes are only honoured while idle so a scan always sees a frozen table.
    assign wr_en  = tbl_we && (state_q == StIdle);
    assign accept = q_valid && q_ready_q && (state_q == StIdle);
    assign hit    = valid_q[idx_q] && (data_q[idx_q] == qreg_q);

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (wr_en) begin
            data_d[tbl_addr]  = tbl_wdata;
            valid_d[tbl_addr] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        qreg_d      = qreg_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        pat_d       = pat_q;
        q_ready_d   = q_ready_q;
        r_valid_d   = r_valid_q;
        r_found_d   = r_found_q;
        r_pattern_d = r_pattern_q;
        r_count_d   = r_count_q;
        busy_d      = busy_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    qreg_d    = q_resp;
                    idx_d     = '0;
                    cnt_d     = '0;
                    first_d   = 1'b0;
                    pat_d     = '0;
                    state_d   = StScan;
                    q_ready_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            StScan: begin
                if (hit) begin
                    cnt_d = cnt_q + (IN_W + 1)'(1);
                    if (!first_q) begin
                        first_d = 1'b1;
                        pat_d   = idx_q;
                    end
                end
                if (idx_q == LastIdx) begin
                    // Results capture this cycle's compare, so use the _d values.
                    state_d     = StDone;
                    r_valid_d   = 1'b1;
                    r_found_d   = first_d;
                    r_pattern_d = pat_d;
                    r_count_d   = cnt_d;
                end else begin
                    idx_d = idx_q + IN_W'(1);
                end
            end
            StDone: begin
                if (r_ready) begin
                    state_d     = StIdle;
                    r_valid_d   = 1'b0;
                    r_found_d   = 1'b0;
                    r_pattern_d = '0;
                    r_count_d   = '0;
                    q_ready_d   = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                r_valid_d   = 1'b0;
                r_found_d   = 1'b0;
                r_pattern_d = '0;
                r_count_d   = '0;
                q_ready_d   = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            qreg_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            pat_q       <= '0;
            q_ready_q   <= 1'b1;
            r_valid_q   <= 1'b0;
            r_found_q   <= 1'b0;
            r_pattern_q <= '0;
            r_count_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            qreg_q      <= qreg_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            pat_q       <= pat_d;
            q_ready_q   <= q_ready_d;
            r_valid_q   <= r_valid_d;
            r_found_q   <= r_found_d;
            r_pattern_q <= r_pattern_d;
            r_count_q   <= r_count_d;
            busy_q      <= busy_d;
        end
    end

    assign q_ready   = q_ready_q;
    assign r_valid   = r_valid_q;
    assign r_found   = r_found_q;
    assign r_pattern = r_pattern_q;
    assign r_count   = r_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aig_response_inverter.sv
// Directed bench for aig_response_inverter; inputs change and outputs are sampled 1ns after
// each rising edge.
module tb_aig_response_inverter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tbl_we;
    logic [3:0]  tbl_addr;
    logic [11:0] tbl_wdata;
    logic        q_valid;
    logic        q_ready;
    logic [11:0] q_resp;
    logic        r_valid;
    logic        r_ready;
    logic        r_found;
    logic [3:0]  r_pattern;
    logic [4:0]  r_count;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    aig_response_inverter #(.IN_W(4), .OUT_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_wdata (tbl_wdata),
        .q_valid   (q_valid),
        .q_ready   (q_ready),
        .q_resp    (q_resp),
        .r_valid   (r_valid),
        .r_ready   (r_ready),
        .r_found   (r_found),
        .r_pattern (r_pattern),
        .r_count   (r_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [3:0] addr, input logic [11:0] data);
        tbl_we    = 1'b1;
        tbl_addr  = addr;
        tbl_wdata = data;
        tick();
        tbl_we    = 1'b0;
    endtask

    // Presents a query, counts edges to r_valid, checks the result and consumes it.
    task automatic run_query(input logic [11:0] resp, input logic found, input logic [3:0] pat,
                             input logic [4:0] cnt, input string tag);
        int n;
        check({tag, "_q_ready"}, 32'(q_ready), 32'd1);
        q_valid = 1'b1;
        q_resp  = resp;
        tick();
        q_valid = 1'b0;
        q_resp  = ~resp;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!r_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd16);
        check({tag, "_found"}, 32'(r_found), 32'(found));
        check({tag, "_pattern"}, 32'(r_pattern), 32'(pat));
        check({tag, "_count"}, 32'(r_count), 32'(cnt));
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        check({tag, "_rvalid_clr"}, 32'(r_valid), 32'd0);
        check({tag, "_count_clr"}, 32'(r_count), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        tbl_we    = 1'b0;
        tbl_addr  = '0;
        tbl_wdata = '0;
        q_valid   = 1'b0;
        q_resp    = '0;
        r_ready   = 1'b0;
        tick();
        tick();
        check("rst_q_ready", 32'(q_ready), 32'd1);
        check("rst_r_valid", 32'(r_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_r_found", 32'(r_found), 32'd0);
        check("rst_r_pattern", 32'(r_pattern), 32'd0);
        check("rst_r_count", 32'(r_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // Empty table: stored zeros are invalid and must not match 0x000.
        run_query(12'h000, 1'b0, 4'd0, 5'd0, "empty");

        for (int i = 0; i < 16; i++) write_entry(4'(i), 12'(i * 12'h101));
        run_query(12'h505, 1'b1, 4'd5, 5'd1, "ramp505");

        for (int i = 0; i < 16; i++) write_entry(4'(i), 12'h000);
        write_entry(4'd3, 12'hABC);
        write_entry(4'd9, 12'hABC);
        write_entry(4'd12, 12'hABC);
        run_query(12'hABC, 1'b1, 4'd3, 5'd3, "dupABC");
        run_query(12'h000, 1'b1, 4'd0, 5'd13, "dup000");

        for (int i = 0; i < 16; i++) write_entry(4'(i), 12'hFFF);
        run_query(12'hFFF, 1'b1, 4'd0, 5'd16, "allFFF");

        // Backpressure in DONE with a competing query held on the input.
        q_valid = 1'b1;
        q_resp  = 12'hFFF;
        tick();
        q_resp  = 12'h000;
        n = 0;
        while (!r_valid && n < 40) begin
            tick();
            n++;
        end
        check("hold_latency", 32'(n), 32'd16);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_r_valid", 32'(r_valid), 32'd1);
            check("hold_r_count", 32'(r_count), 32'd16);
            check("hold_r_pattern", 32'(r_pattern), 32'd0);
            check("hold_q_ready", 32'(q_ready), 32'd0);
        end
        r_ready = 1'b1;
        q_resp  = 12'hFFF;
        tick();
        r_ready = 1'b0;
        check("release_r_valid", 32'(r_valid), 32'd0);
        check("release_q_ready", 32'(q_ready), 32'd1);
        check("release_busy", 32'(busy), 32'd0);
        tick();
        q_valid = 1'b0;
        check("late_accept_busy", 32'(busy), 32'd1);
        check("late_accept_q_ready", 32'(q_ready), 32'd0);
        n = 0;
        while (!r_valid && n < 40) begin
            tick();
            n++;
        end
        check("late_latency", 32'(n), 32'd16);
        check("late_count", 32'(r_count), 32'd16);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;

        // A write issued mid-scan must be dropped.
        q_valid = 1'b1;
        q_resp  = 12'h123;
        tick();
        q_valid = 1'b0;
        tick();
        write_entry(4'd5, 12'h123);
        n = 0;
        while (!r_valid && n < 40) begin
            tick();
            n++;
        end
        check("scanwr_found", 32'(r_found), 32'd0);
        r_ready = 1'b1;
        tick();
        r_ready = 1'b0;
        run_query(12'h123, 1'b0, 4'd0, 5'd0, "after_scanwr");

        // Reset in the middle of a scan abandons it and invalidates the table.
        for (int i = 0; i < 16; i++) write_entry(4'(i), 12'(i * 12'h101));
        q_valid = 1'b1;
        q_resp  = 12'h505;
        tick();
        q_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_r_valid", 32'(r_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_q_ready", 32'(q_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        run_query(12'h505, 1'b0, 4'd0, 5'd0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
